// File: rtl/sram_req_arbiter_pkg.sv
// Shared definitions for the SRAM request arbiter: master ids, size codes, payload struct.
package sram_req_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned STRB_W = 4;

  localparam logic MID_INST = 1'b0;
  localparam logic MID_DATA = 1'b1;

  localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
  localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
  localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } sram_payload_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

endpackage

// File: rtl/sram_req_arbiter_if.sv
// SRAM-like channel (req/addr_ok/data_ok); master drives the request, slave answers.
interface sram_req_arbiter_if;
  import sram_req_arbiter_pkg::*;

  logic              req;
  logic              wr;
  logic [SIZE_W-1:0] size;
  logic [STRB_W-1:0] wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/sram_order_fifo.sv
// Issue-order FIFO of 1-bit master ids for in-flight SRAM transactions.
module sram_order_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [OCC_W-1:0] occ_q;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (occ_q == OCC_W'(DEPTH));
  assign empty   = (occ_q == '0);
  assign head    = mem_q[rptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= push_id;
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (do_pop) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      occ_q <= occ_q + OCC_W'(do_push) - OCC_W'(do_pop);
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like port between the instruction and data requesters,
// fixed priority data > inst, with responses routed back in issue order.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTST = 2,
  parameter int unsigned CNT_W     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  sram_req_arbiter_if.slave          inst,
  sram_req_arbiter_if.slave          data,
  sram_req_arbiter_if.master         sram
);

  lock_state_e   state_q;
  lock_state_e   state_d;
  logic          lock_mid_q;
  logic          lock_mid_d;
  logic [CNT_W-1:0] outst_q;
  logic [CNT_W-1:0] outst_d;

  logic          grant_c;
  logic          blocked_c;
  logic          req_c;
  logic          handshake_c;
  logic          pop_c;
  logic          head_c;
  logic          fifo_empty;
  logic          fifo_full;
  sram_payload_t inst_pl_c;
  sram_payload_t data_pl_c;
  sram_payload_t sel_pl_c;
  logic          unused_c;

  // While locked the grantee is frozen until its address phase is accepted.
  always_comb begin
    grant_c = data.req ? MID_DATA : MID_INST;
    if (state_q == ST_LOCKED) begin
      grant_c = lock_mid_q;
    end
  end

  assign blocked_c   = (outst_q == CNT_W'(MAX_OUTST));
  assign req_c       = ~reset & ~blocked_c & (data.req | inst.req);
  assign handshake_c = req_c & sram.addr_ok;
  assign pop_c       = sram.data_ok & ~fifo_empty;

  assign inst_pl_c = '{wr: 1'b0, size: SIZE_WORD, wstrb: '0, addr: inst.addr, wdata: '0};
  assign data_pl_c = '{wr: data.wr, size: data.size, wstrb: data.wstrb,
                       addr: data.addr, wdata: data.wdata};

  always_comb begin
    sel_pl_c = '0;
    if (req_c) begin
      sel_pl_c = (grant_c == MID_DATA) ? data_pl_c : inst_pl_c;
    end
  end

  assign sram.req   = req_c;
  assign sram.wr    = sel_pl_c.wr;
  assign sram.size  = sel_pl_c.size;
  assign sram.wstrb = sel_pl_c.wstrb;
  assign sram.addr  = sel_pl_c.addr;
  assign sram.wdata = sel_pl_c.wdata;

  assign inst.addr_ok = handshake_c & (grant_c == MID_INST);
  assign data.addr_ok = handshake_c & (grant_c == MID_DATA);
  assign inst.data_ok = pop_c & (head_c == MID_INST);
  assign data.data_ok = pop_c & (head_c == MID_DATA);
  assign inst.rdata   = sram.rdata;
  assign data.rdata   = sram.rdata;

  // Lock FSM: next state and captured grantee.
  always_comb begin
    state_d    = state_q;
    lock_mid_d = lock_mid_q;
    case (state_q)
      ST_IDLE: begin
        if (req_c && !sram.addr_ok) begin
          state_d    = ST_LOCKED;
          lock_mid_d = grant_c;
        end
      end
      ST_LOCKED: begin
        if (handshake_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    outst_d = outst_q + CNT_W'(handshake_c) - CNT_W'(pop_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lock_mid_q <= MID_INST;
      outst_q    <= '0;
    end else begin
      state_q    <= state_d;
      lock_mid_q <= lock_mid_d;
      outst_q    <= outst_d;
    end
  end

  sram_order_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_order_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (handshake_c),
    .push_id (grant_c),
    .pop     (pop_c),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head_c)
  );

  // Instruction side is read-only; its write-side fields are intentionally ignored.
  assign unused_c = ^{inst.wr, inst.size, inst.wstrb, inst.wdata, fifo_full};

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed self-checking bench for sram_req_arbiter.
module tb_sram_req_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   stray_cnt;

  sram_req_arbiter_if inst_if ();
  sram_req_arbiter_if data_if ();
  sram_req_arbiter_if sram_if ();

  sram_req_arbiter #(
    .MAX_OUTST (2),
    .CNT_W     (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .inst  (inst_if),
    .data  (data_if),
    .sram  (sram_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responses arriving with nothing outstanding must not be routed anywhere.
  always @(posedge clk) begin
    if (!reset && sram_if.data_ok && !inst_if.data_ok && !data_if.data_ok)
      stray_cnt <= stray_cnt + 1;
  end

  task automatic idle();
    inst_if.req = 1'b0; inst_if.wr = 1'b0; inst_if.size = 2'd0; inst_if.wstrb = 4'h0;
    inst_if.addr = 32'h0; inst_if.wdata = 32'h0;
    data_if.req = 1'b0; data_if.wr = 1'b0; data_if.size = 2'd0; data_if.wstrb = 4'h0;
    data_if.addr = 32'h0; data_if.wdata = 32'h0;
    sram_if.addr_ok = 1'b0; sram_if.data_ok = 1'b0; sram_if.rdata = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    inst_if.req = 1'b1; inst_if.addr = 32'h1c000000;
    sram_if.addr_ok = 1'b1; sram_if.data_ok = 1'b1;
    @(negedge clk); #1;
    checks++; if (sram_if.req !== 1'b0) begin errors++; $display("FAIL rst_sram_req got %b exp 0", sram_if.req); end
    checks++; if (sram_if.addr !== 32'h0) begin errors++; $display("FAIL rst_sram_addr got %h exp 0", sram_if.addr); end
    checks++; if (inst_if.addr_ok !== 1'b0) begin errors++; $display("FAIL rst_inst_addr_ok got %b exp 0", inst_if.addr_ok); end
    checks++; if ({inst_if.data_ok, data_if.data_ok} !== 2'b00) begin errors++; $display("FAIL rst_data_ok got %b exp 00", {inst_if.data_ok, data_if.data_ok}); end
    @(negedge clk);
    idle();
    reset = 1'b0;
  endtask

  task automatic test_inst_only();
    @(negedge clk);
    inst_if.req = 1'b1; inst_if.addr = 32'h1c000000; sram_if.addr_ok = 1'b1;
    #1;
    checks++; if (sram_if.req !== 1'b1) begin errors++; $display("FAIL io_sram_req got %b exp 1", sram_if.req); end
    checks++; if (sram_if.addr !== 32'h1c000000) begin errors++; $display("FAIL io_sram_addr got %h exp 1c000000", sram_if.addr); end
    checks++; if ({sram_if.wr, sram_if.size, sram_if.wstrb} !== 7'b0_10_0000) begin errors++; $display("FAIL io_payload got %b exp 0100000", {sram_if.wr, sram_if.size, sram_if.wstrb}); end
    checks++; if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b10) begin errors++; $display("FAIL io_addr_ok got %b exp 10", {inst_if.addr_ok, data_if.addr_ok}); end
    @(negedge clk);
    idle();
    sram_if.data_ok = 1'b1; sram_if.rdata = 32'h02800405;
    #1;
    checks++; if ({inst_if.data_ok, data_if.data_ok} !== 2'b10) begin errors++; $display("FAIL io_data_ok got %b exp 10", {inst_if.data_ok, data_if.data_ok}); end
    checks++; if (inst_if.rdata !== 32'h02800405) begin errors++; $display("FAIL io_rdata got %h exp 02800405", inst_if.rdata); end
    @(negedge clk);
    idle();
    #1;
    checks++; if ({inst_if.data_ok, data_if.data_ok, sram_if.req} !== 3'b000) begin errors++; $display("FAIL io_quiet got %b exp 000", {inst_if.data_ok, data_if.data_ok, sram_if.req}); end
  endtask

  task automatic test_priority();
    @(negedge clk);
    inst_if.req = 1'b1; inst_if.addr = 32'h1c000010;
    data_if.req = 1'b1; data_if.wr = 1'b1; data_if.size = 2'd2; data_if.wstrb = 4'hf;
    data_if.addr = 32'h00001000; data_if.wdata = 32'hdeadbeef;
    sram_if.addr_ok = 1'b1;
    #1;
    checks++; if (sram_if.addr !== 32'h00001000) begin errors++; $display("FAIL pri_addr0 got %h exp 00001000", sram_if.addr); end
    checks++; if ({sram_if.wr, sram_if.wstrb, sram_if.wdata} !== {1'b1, 4'hf, 32'hdeadbeef}) begin errors++; $display("FAIL pri_payload got %h exp 1fdeadbeef", {sram_if.wr, sram_if.wstrb, sram_if.wdata}); end
    checks++; if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b01) begin errors++; $display("FAIL pri_addr_ok0 got %b exp 01", {inst_if.addr_ok, data_if.addr_ok}); end
    @(negedge clk);
    data_if.req = 1'b0; data_if.wr = 1'b0;
    #1;
    checks++; if (sram_if.addr !== 32'h1c000010) begin errors++; $display("FAIL pri_addr1 got %h exp 1c000010", sram_if.addr); end
    checks++; if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b10) begin errors++; $display("FAIL pri_addr_ok1 got %b exp 10", {inst_if.addr_ok, data_if.addr_ok}); end
    @(negedge clk);
    idle();
    sram_if.data_ok = 1'b1; sram_if.rdata = 32'h11111111;
    #1;
    checks++; if ({inst_if.data_ok, data_if.data_ok} !== 2'b01) begin errors++; $display("FAIL pri_resp0 got %b exp 01", {inst_if.data_ok, data_if.data_ok}); end
    @(negedge clk);
    sram_if.rdata = 32'h22222222;
    #1;
    checks++; if ({inst_if.data_ok, data_if.data_ok} !== 2'b10) begin errors++; $display("FAIL pri_resp1 got %b exp 10", {inst_if.data_ok, data_if.data_ok}); end
    checks++; if (inst_if.rdata !== 32'h22222222) begin errors++; $display("FAIL pri_rdata1 got %h exp 22222222", inst_if.rdata); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_lock();
    @(negedge clk);
    inst_if.req = 1'b1; inst_if.addr = 32'h1c000020;
    #1;
    checks++; if (sram_if.addr !== 32'h1c000020) begin errors++; $display("FAIL lock_addr0 got %h exp 1c000020", sram_if.addr); end
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      data_if.req = 1'b1; data_if.addr = 32'h00002000; data_if.size = 2'd2;
      #1;
      checks++; if (sram_if.addr !== 32'h1c000020) begin errors++; $display("FAIL lock_addr_hold%0d got %h exp 1c000020", c, sram_if.addr); end
    end
    @(negedge clk);
    sram_if.addr_ok = 1'b1;
    #1;
    checks++; if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b10) begin errors++; $display("FAIL lock_release got %b exp 10", {inst_if.addr_ok, data_if.addr_ok}); end
    @(negedge clk);
    inst_if.req = 1'b0;
    #1;
    checks++; if (sram_if.addr !== 32'h00002000) begin errors++; $display("FAIL lock_data_addr got %h exp 00002000", sram_if.addr); end
    checks++; if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b01) begin errors++; $display("FAIL lock_data_ok got %b exp 01", {inst_if.addr_ok, data_if.addr_ok}); end
    @(negedge clk);
    idle();
    sram_if.data_ok = 1'b1;
    #1;
    checks++; if ({inst_if.data_ok, data_if.data_ok} !== 2'b10) begin errors++; $display("FAIL lock_resp0 got %b exp 10", {inst_if.data_ok, data_if.data_ok}); end
    @(negedge clk);
    #1;
    checks++; if ({inst_if.data_ok, data_if.data_ok} !== 2'b01) begin errors++; $display("FAIL lock_resp1 got %b exp 01", {inst_if.data_ok, data_if.data_ok}); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_full();
    @(negedge clk);
    inst_if.req = 1'b1; inst_if.addr = 32'h1c000100; sram_if.addr_ok = 1'b1;
    @(negedge clk);
    inst_if.addr = 32'h1c000104;
    #1;
    checks++; if (inst_if.addr_ok !== 1'b1) begin errors++; $display("FAIL full_second_accept got %b exp 1", inst_if.addr_ok); end
    @(negedge clk);
    inst_if.addr = 32'h1c000108;
    data_if.req = 1'b1; data_if.addr = 32'h00003000; data_if.size = 2'd1;
    #1;
    checks++; if (sram_if.req !== 1'b0) begin errors++; $display("FAIL full_blocked got %b exp 0", sram_if.req); end
    checks++; if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b00) begin errors++; $display("FAIL full_addr_ok got %b exp 00", {inst_if.addr_ok, data_if.addr_ok}); end
    @(negedge clk);
    sram_if.data_ok = 1'b1; sram_if.rdata = 32'h0000aaaa;
    #1;
    checks++; if (sram_if.req !== 1'b0) begin errors++; $display("FAIL full_no_issue_through got %b exp 0", sram_if.req); end
    checks++; if (inst_if.data_ok !== 1'b1) begin errors++; $display("FAIL full_pop got %b exp 1", inst_if.data_ok); end
    @(negedge clk);
    sram_if.data_ok = 1'b0;
    #1;
    checks++; if (sram_if.req !== 1'b1) begin errors++; $display("FAIL full_resume got %b exp 1", sram_if.req); end
    checks++; if ({sram_if.addr, sram_if.size} !== {32'h00003000, 2'd1}) begin errors++; $display("FAIL full_resume_payload got %h exp 00003000/1", {sram_if.addr, sram_if.size}); end
    checks++; if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b01) begin errors++; $display("FAIL full_resume_ok got %b exp 01", {inst_if.addr_ok, data_if.addr_ok}); end
    @(negedge clk);
    idle();
    sram_if.data_ok = 1'b1;
    #1;
    checks++; if ({inst_if.data_ok, data_if.data_ok} !== 2'b10) begin errors++; $display("FAIL full_resp1 got %b exp 10", {inst_if.data_ok, data_if.data_ok}); end
    @(negedge clk);
    #1;
    checks++; if ({inst_if.data_ok, data_if.data_ok} !== 2'b01) begin errors++; $display("FAIL full_resp2 got %b exp 01", {inst_if.data_ok, data_if.data_ok}); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_back_to_back_wrap();
    logic [7:0] pat;
    pat = 8'b1011_0010;
    @(negedge clk);
    inst_if.req = 1'b1; inst_if.addr = 32'h00000100; sram_if.addr_ok = 1'b1;
    #1;
    checks++; if (inst_if.addr_ok !== 1'b1) begin errors++; $display("FAIL wrap_issue0 got %b exp 1", inst_if.addr_ok); end
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      idle();
      if (pat[i]) begin data_if.req = 1'b1; data_if.addr = 32'h100 + 32'(4 * i); data_if.size = 2'd2; end
      else        begin inst_if.req = 1'b1; inst_if.addr = 32'h100 + 32'(4 * i); end
      sram_if.addr_ok = 1'b1;
      sram_if.data_ok = 1'b1; sram_if.rdata = 32'ha0 + 32'(i - 1);
      #1;
      checks++; if (sram_if.req !== 1'b1) begin errors++; $display("FAIL wrap_req%0d got %b exp 1", i, sram_if.req); end
      checks++; if ({data_if.addr_ok, inst_if.addr_ok} !== {pat[i], ~pat[i]}) begin errors++; $display("FAIL wrap_addr_ok%0d got %b exp %b", i, {data_if.addr_ok, inst_if.addr_ok}, {pat[i], ~pat[i]}); end
      checks++; if ({data_if.data_ok, inst_if.data_ok} !== {pat[i-1], ~pat[i-1]}) begin errors++; $display("FAIL wrap_data_ok%0d got %b exp %b", i - 1, {data_if.data_ok, inst_if.data_ok}, {pat[i-1], ~pat[i-1]}); end
    end
    @(negedge clk);
    idle();
    sram_if.data_ok = 1'b1; sram_if.rdata = 32'ha7;
    #1;
    checks++; if ({data_if.data_ok, inst_if.data_ok} !== {pat[7], ~pat[7]}) begin errors++; $display("FAIL wrap_data_ok7 got %b exp %b", {data_if.data_ok, inst_if.data_ok}, {pat[7], ~pat[7]}); end
    checks++; if (data_if.rdata !== 32'ha7) begin errors++; $display("FAIL wrap_rdata7 got %h exp a7", data_if.rdata); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    inst_if.req = 1'b1; inst_if.addr = 32'h1c000200; sram_if.addr_ok = 1'b1;
    @(negedge clk);
    inst_if.addr = 32'h1c000204;
    @(negedge clk);
    inst_if.addr = 32'h1c000208;
    data_if.req = 1'b1; data_if.addr = 32'h00004000;
    #1;
    checks++; if (sram_if.req !== 1'b0) begin errors++; $display("FAIL mid_full got %b exp 0", sram_if.req); end
    #1;
    reset = 1'b1;
    sram_if.data_ok = 1'b1;
    #1;
    checks++; if ({sram_if.req, inst_if.addr_ok, data_if.addr_ok} !== 3'b000) begin errors++; $display("FAIL mid_rst_req got %b exp 000", {sram_if.req, inst_if.addr_ok, data_if.addr_ok}); end
    checks++; if ({inst_if.data_ok, data_if.data_ok} !== 2'b00) begin errors++; $display("FAIL mid_rst_data_ok got %b exp 00", {inst_if.data_ok, data_if.data_ok}); end
    @(negedge clk);
    idle();
    reset = 1'b0;
    sram_if.data_ok = 1'b1;
    #1;
    checks++; if ({inst_if.data_ok, data_if.data_ok} !== 2'b00) begin errors++; $display("FAIL mid_stray got %b exp 00", {inst_if.data_ok, data_if.data_ok}); end
    @(negedge clk);
    idle();
    inst_if.req = 1'b1; inst_if.addr = 32'h1c000300; sram_if.addr_ok = 1'b1;
    #1;
    checks++; if ({sram_if.req, inst_if.addr_ok} !== 2'b11) begin errors++; $display("FAIL mid_reissue got %b exp 11", {sram_if.req, inst_if.addr_ok}); end
    @(negedge clk);
    idle();
    sram_if.data_ok = 1'b1;
    #1;
    checks++; if (inst_if.data_ok !== 1'b1) begin errors++; $display("FAIL mid_resp got %b exp 1", inst_if.data_ok); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (stray_cnt !== 1) begin errors++; $display("FAIL stray_count got %0d exp 1", stray_cnt); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    stray_cnt = 0;
    test_reset();
    test_inst_only();
    test_priority();
    test_lock();
    test_full();
    test_back_to_back_wrap();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
